spi_wr_arbiter: RTL and testbench
=================================

// Module: spi_wr_arbiter
// PURPOSE
//  Shares one word-level SPI write engine (16-bit frame, CSN/SCK/SDI generation) between two requesters.
//  Requester 0 is the power-up config sequencer; requester 1 is the runtime register-write port.
//  Arbitrates round-robin, latches the granted word, and launches the engine with a start/done handshake.
//  Enforces a minimum CSN-high gap between frames and flags an engine that never completes.
// PARAMETERS
//  DW       16    frame width, bits; applies to data0/data1/eng_data
//  GAP_CYC  8     sclk cycles spent in GAP after each frame (min inter-frame spacing); must be >=1
//  TO_CYC   4096  sclk cycles allowed in ACTIVE before timeout; must be >=2
// PORTS
//  sclk         in   1    system clock, 50 MHz; all logic on rising edge
//  rst          in   1    synchronous, active-high reset
//  req0         in   1    requester 0 word request; level, held until ack0
//  data0        in   DW   requester 0 word; stable while req0 high
//  ack0         out  1    1-cycle pulse: data0 latched, requester 0 may drop req0 or present its next word
//  req1         in   1    requester 1 word request; level, held until ack1
//  data1        in   DW   requester 1 word; stable while req1 high
//  ack1         out  1    1-cycle pulse: data1 latched
//  eng_start    out  1    1-cycle pulse launching the engine
//  eng_data     out  DW   latched word; held stable from eng_start until the end of the frame
//  eng_busy     in   1    engine mid-frame; no start is issued while high
//  eng_done     in   1    1-cycle pulse: engine finished the frame (CSN released)
//  busy         out  1    high in ACTIVE and GAP
//  grant_id     out  1    requester owning the current/last frame
//  timeout_err  out  1    sticky; set on timeout, cleared only by rst
// BEHAVIOUR
//  Reset (any cycle, including mid-frame): state=IDLE, ack0=ack1=0, eng_start=0, eng_data=0, busy=0, grant_id=0,
//   timeout_err=0, last_grant=1 (so req0 wins the first tie), all counters=0; the latched word is discarded.
//  FSM states IDLE, ACTIVE, GAP; all outputs registered.
//  IDLE: if (req0|req1) && !eng_busy at edge E:
//   - winner = the only requester, or the one != last_grant on a tie;
//   - at E: latch winner data, grant_id<=winner, last_grant<=winner, ack_winner<=1, eng_start<=1, ->ACTIVE.
//   - Latency: request seen in cycle N -> ack and eng_start both high in cycle N+1, for exactly 1 cycle.
//   - eng_busy high: stay IDLE, no ack; requests keep waiting.
//  ACTIVE: to_cnt increments every cycle from 0.
//   - eng_done=1 -> GAP, to_cnt<=0.
//   - else if to_cnt==TO_CYC-1 -> timeout_err<=1, GAP (frame abandoned, no retry).
//   - eng_done and the timeout in the same cycle: done wins, timeout_err unchanged.
//   - Requests arriving here are not acked until the next IDLE.
//  GAP: gap_cnt counts 0..GAP_CYC-1, then IDLE; eng_done seen in GAP is ignored.
//  Minimum frame-to-frame spacing: done at cycle D -> earliest next eng_start at D+GAP_CYC+2.
//  Fairness: with both reqs held continuously, grants alternate 0,1,0,1...; one requester cannot win twice
//   in a row while the other waits.
//  A req dropped before its ack withdraws the request; no ack, no frame.
//  ack0 and ack1 are never high together; eng_start never fires outside IDLE->ACTIVE.
//  eng_data changes only on the grant edge.
// TESTING
//  1 rst, req0=1 data0=16'hA55A in cycle N -> ack0 and eng_start in N+1, eng_data=A55A, grant_id=0, busy=1.
//  2 req0 and req1 rise together after rst (data 16'h0001/16'h0002) -> frames 0001 then 0002; second eng_start
//    exactly GAP_CYC+2 cycles after the first eng_done.
//  3 req0 and req1 held for 4 frames, eng_done 20 cycles after each start -> grant_id sequence 0,1,0,1;
//    exactly 2 acks per requester.
//  4 eng_done never asserted, TO_CYC=16 -> timeout_err rises 16 cycles after eng_start, stays 1; FSM returns
//    to IDLE after GAP and serves the next request.
//  5 eng_busy=1 with req1 held 50 cycles -> no ack1, no eng_start; eng_busy drops -> ack1 the next cycle.
//  6 rst pulsed 1 cycle during ACTIVE -> next cycle all outputs at reset values; late eng_done ignored;
//    a pending req1 is served normally after reset.

Source files
------------

// File: rtl/spi_wr_arbiter.sv
// Round-robin arbiter sharing one word-level SPI write engine between two requesters.
// Grants in IDLE, tracks the frame in ACTIVE with a timeout, then holds a CSN-high GAP.
module spi_wr_arbiter #(
    parameter int unsigned DW      = 16,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TO_CYC  = 4096
) (
    input  logic          sclk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic [DW-1:0] data0_i,
    output logic          ack0_o,
    input  logic          req1_i,
    input  logic [DW-1:0] data1_i,
    output logic          ack1_o,
    output logic          eng_start_o,
    output logic [DW-1:0] eng_data_o,
    input  logic          eng_busy_i,
    input  logic          eng_done_i,
    output logic          busy_o,
    output logic          grant_id_o,
    output logic          timeout_err_o
);

    localparam int unsigned TW = $clog2(TO_CYC);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_id_q, grant_id_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          eng_start_q, eng_start_d;
    logic [DW-1:0] eng_data_q, eng_data_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          winner;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        eng_start_d  = 1'b0;
        eng_data_d   = eng_data_q;
        timeout_d    = timeout_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        winner       = 1'b0;

        case (state_q)
            IDLE: begin
                if ((req0_i || req1_i) && !eng_busy_i) begin
                    // A tie goes to whoever did not own the previous frame.
                    if (req0_i && req1_i) winner = ~last_grant_q;
                    else                  winner = req1_i;
                    eng_data_d   = winner ? data1_i : data0_i;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    ack0_d       = ~winner;
                    ack1_d       = winner;
                    eng_start_d  = 1'b1;
                    to_cnt_d     = '0;
                    state_d      = ACTIVE;
                end
            end
            ACTIVE: begin
                if (eng_done_i) begin
                    to_cnt_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (to_cnt_q == TW'(TO_CYC - 1)) begin
                    timeout_d = 1'b1;
                    to_cnt_d  = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_data_q   <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            eng_start_q  <= eng_start_d;
            eng_data_q   <= eng_data_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign eng_start_o   = eng_start_q;
    assign eng_data_o    = eng_data_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_id_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_spi_wr_arbiter.sv
// Directed bench for spi_wr_arbiter: one main instance plus a short-timeout instance
// sharing the same stimulus.
module tb_spi_wr_arbiter;

    localparam int unsigned DW   = 16;
    localparam int unsigned GAP  = 8;
    localparam int unsigned TO   = 64;
    localparam int unsigned TO_S = 16;

    logic          clk = 1'b0;
    logic          rst, req0, req1, eng_busy, eng_done;
    logic [DW-1:0] data0, data1;

    logic          ack0, ack1, eng_start, busy, grant_id, timeout_err;
    logic [DW-1:0] eng_data;
    logic          t_ack0, t_ack1, t_eng_start, t_busy, t_grant_id, t_timeout_err;
    logic [DW-1:0] t_eng_data;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    spi_wr_arbiter #(.DW(DW), .GAP_CYC(GAP), .TO_CYC(TO)) dut (
        .sclk_i(clk), .rst_i(rst),
        .req0_i(req0), .data0_i(data0), .ack0_o(ack0),
        .req1_i(req1), .data1_i(data1), .ack1_o(ack1),
        .eng_start_o(eng_start), .eng_data_o(eng_data),
        .eng_busy_i(eng_busy), .eng_done_i(eng_done),
        .busy_o(busy), .grant_id_o(grant_id), .timeout_err_o(timeout_err)
    );

    spi_wr_arbiter #(.DW(DW), .GAP_CYC(GAP), .TO_CYC(TO_S)) dut_to (
        .sclk_i(clk), .rst_i(rst),
        .req0_i(req0), .data0_i(data0), .ack0_o(t_ack0),
        .req1_i(req1), .data1_i(data1), .ack1_o(t_ack1),
        .eng_start_o(t_eng_start), .eng_data_o(t_eng_data),
        .eng_busy_i(eng_busy), .eng_done_i(eng_done),
        .busy_o(t_busy), .grant_id_o(t_grant_id), .timeout_err_o(t_timeout_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        eng_busy = 1'b0; eng_done = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic finish_frame;
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        repeat (GAP) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 16'hFFFF; data1 = 16'hFFFF;
        eng_busy = 1'b0; eng_done = 1'b0;
        tick;
        checks++;
        if ({ack0, ack1, eng_start, busy, grant_id, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ack0, ack1, eng_start, busy, grant_id, timeout_err});
        end
        checks++;
        if (eng_data !== 16'h0000) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", eng_data);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        req0 = 1'b1; data0 = 16'hA55A;
        tick;
        checks++;
        if ({ack0, ack1, eng_start, grant_id, busy} !== 5'b10101) begin
            errors++;
            $display("FAIL single_grant: ack0,ack1,start,gid,busy got %b expected 10101",
                     {ack0, ack1, eng_start, grant_id, busy});
        end
        checks++;
        if (eng_data !== 16'hA55A) begin
            errors++; $display("FAIL single_data: got %h expected a55a", eng_data);
        end
        req0 = 1'b0;
        tick;
        checks++;
        if ({ack0, eng_start, busy} !== 3'b001) begin
            errors++; $display("FAIL single_pulse: got %b expected 001", {ack0, eng_start, busy});
        end
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        repeat (GAP - 1) tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL gap_last_cycle_busy: got %b expected 1", busy);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL gap_exit_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_tie_spacing;
        int k;
        int early;
        early = 0;
        do_reset;
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h0001; data1 = 16'h0002;
        tick;
        checks++;
        if ({ack0, ack1, grant_id} !== 3'b100 || eng_data !== 16'h0001) begin
            errors++;
            $display("FAIL tie_first: ack0,ack1,gid got %b data %h expected 100 data 0001",
                     {ack0, ack1, grant_id}, eng_data);
        end
        req0 = 1'b0;
        repeat (5) begin
            tick;
            if (ack1) early++;
        end
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        k = 1;
        while (!eng_start && k < 40) begin
            if (ack1) early++;
            tick;
            k++;
        end
        checks++;
        if (k != GAP + 2) begin
            errors++; $display("FAIL tie_spacing: got %0d cycles expected %0d", k, GAP + 2);
        end
        checks++;
        if ({ack1, grant_id} !== 2'b11 || eng_data !== 16'h0002 || early != 0) begin
            errors++;
            $display("FAIL tie_second: ack1,gid got %b data %h early acks %0d expected 11 data 0002 early 0",
                     {ack1, grant_id}, eng_data, early);
        end
        req1 = 1'b0;
        tick;
        finish_frame;
    endtask

    task automatic test_fairness;
        int a0, a1, both, k;
        a0 = 0; a1 = 0; both = 0;
        do_reset;
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h0010; data1 = 16'h0020;
        for (int f = 0; f < 4; f++) begin
            k = 0;
            while (!eng_start && k < 30) begin
                tick;
                k++;
            end
            if (ack0) a0++;
            if (ack1) a1++;
            if (ack0 && ack1) both++;
            checks++;
            if (!eng_start || grant_id !== 1'(f % 2)) begin
                errors++;
                $display("FAIL fair_grant[%0d]: start %b gid %b expected start 1 gid %0d",
                         f, eng_start, grant_id, f % 2);
            end
            checks++;
            if (eng_data !== ((f % 2) ? 16'h0020 : 16'h0010)) begin
                errors++; $display("FAIL fair_data[%0d]: got %h", f, eng_data);
            end
            repeat (20) begin
                tick;
                if (ack0) a0++;
                if (ack1) a1++;
            end
            eng_done = 1'b1;
            tick;
            eng_done = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (GAP) tick;
        checks++;
        if (a0 != 2 || a1 != 2 || both != 0) begin
            errors++;
            $display("FAIL fair_ack_count: ack0 %0d ack1 %0d both %0d expected 2 2 0", a0, a1, both);
        end
    endtask

    task automatic test_timeout_race;
        do_reset;
        req0 = 1'b1; data0 = 16'h00C3;
        tick;
        req0 = 1'b0;
        repeat (15) tick;
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0;
        checks++;
        if ({t_timeout_err, t_busy} !== 2'b01) begin
            errors++;
            $display("FAIL done_beats_timeout: terr,busy got %b expected 01", {t_timeout_err, t_busy});
        end
        repeat (GAP) tick;
    endtask

    task automatic test_timeout;
        do_reset;
        req0 = 1'b1; data0 = 16'hBEEF;
        tick;
        req0 = 1'b0;
        checks++;
        if (t_eng_start !== 1'b1) begin
            errors++; $display("FAIL to_start: got %b expected 1", t_eng_start);
        end
        repeat (15) tick;
        checks++;
        if (t_timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_early: got %b expected 0", t_timeout_err);
        end
        tick;
        checks++;
        if ({t_timeout_err, t_busy} !== 2'b11) begin
            errors++; $display("FAIL to_set: terr,busy got %b expected 11", {t_timeout_err, t_busy});
        end
        repeat (GAP) tick;
        checks++;
        if ({t_timeout_err, t_busy} !== 2'b10) begin
            errors++; $display("FAIL to_idle: terr,busy got %b expected 10", {t_timeout_err, t_busy});
        end
        req1 = 1'b1; data1 = 16'h1234;
        tick;
        req1 = 1'b0;
        checks++;
        if ({t_ack1, t_eng_start, t_grant_id, t_timeout_err} !== 4'b1111 || t_eng_data !== 16'h1234) begin
            errors++;
            $display("FAIL to_next_served: ack1,start,gid,terr got %b data %h expected 1111 data 1234",
                     {t_ack1, t_eng_start, t_grant_id, t_timeout_err}, t_eng_data);
        end
    endtask

    task automatic test_busy_block;
        int viol;
        viol = 0;
        do_reset;
        eng_busy = 1'b1; req1 = 1'b1; data1 = 16'h5A5A;
        repeat (50) begin
            tick;
            if (ack0 || ack1 || eng_start) viol++;
        end
        checks++;
        if (viol != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_blocks: grants %0d busy %b expected 0 0", viol, busy);
        end
        eng_busy = 1'b0;
        tick;
        checks++;
        if ({ack1, eng_start, grant_id} !== 3'b111 || eng_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL busy_release: ack1,start,gid got %b data %h expected 111 data 5a5a",
                     {ack1, eng_start, grant_id}, eng_data);
        end
        req1 = 1'b0;
        tick;
        finish_frame;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req0 = 1'b1; data0 = 16'h7777;
        tick;
        req0 = 1'b0; req1 = 1'b1; data1 = 16'h3333;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({ack0, ack1, eng_start, busy, grant_id, timeout_err} !== 6'b0 || eng_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: ctrl %b data %h expected 000000 data 0000",
                     {ack0, ack1, eng_start, busy, grant_id, timeout_err}, eng_data);
        end
        eng_done = 1'b1;
        tick;
        eng_done = 1'b0; req1 = 1'b0;
        checks++;
        if ({ack1, eng_start, grant_id} !== 3'b111 || eng_data !== 16'h3333) begin
            errors++;
            $display("FAIL mid_reset_serve: ack1,start,gid got %b data %h expected 111 data 3333",
                     {ack1, eng_start, grant_id}, eng_data);
        end
        repeat (GAP + 3) tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL late_done_ignored: busy got %b expected 1", busy);
        end
        finish_frame;
    endtask

    initial begin
        test_reset;
        test_single;
        test_tie_spacing;
        test_fairness;
        test_timeout_race;
        test_timeout;
        test_busy_block;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
